// File: rtl/alu_display_pkg.sv
// Shared state encoding and sizing helpers for the ALU display scheduler.
package alu_display_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHOW   = 2'd1;
  localparam logic [1:0] ST_URGENT = 2'd2;

  localparam logic [1:0] SEL_URGENT = 2'd3;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/alu_display_if.sv
// Source/urgent/display bundle between the ALU datapath and the display path.
interface alu_display_if #(
  parameter int N_SRC = 3,
  parameter int WIDTH = 6
);

  logic [N_SRC*WIDTH-1:0] src_values;
  logic [N_SRC-1:0]       src_valid;
  logic                   hold;
  logic                   urgent_req;
  logic [WIDTH-1:0]       urgent_value;
  logic                   urgent_ack;
  logic [WIDTH-1:0]       value;
  logic                   value_valid;
  logic [1:0]             src_sel;
  logic                   slot_start;

  modport master (
    output src_values, src_valid, hold,
    output urgent_req, urgent_value,
    input  urgent_ack, value, value_valid,
    input  src_sel, slot_start
  );

  modport slave (
    input  src_values, src_valid, hold,
    input  urgent_req, urgent_value,
    output urgent_ack, value, value_valid,
    output src_sel, slot_start
  );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter shared by source and urgent slots.
module dwell_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/alu_display_scheduler.sv
// Rotates ALU sources onto the display with hold and urgent override.
// Urgent channel present only when ALU_DISP_URGENT_EN is defined.
module alu_display_scheduler
  import alu_display_pkg::*;
#(
  parameter int N_SRC         = 3,
  parameter int WIDTH         = 6,
  parameter int DWELL_CYCLES  = 200_000_000,
  parameter int URGENT_CYCLES = 300_000_000
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  alu_display_if.slave  bus
);

  localparam int CW = cnt_width(DWELL_CYCLES, URGENT_CYCLES);
  localparam logic [CW-1:0] LD_DWELL = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] LD_URG   = CW'(URGENT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_sel;
  logic [1:0]       r_ret;
  logic             r_ret_idle;
  logic [WIDTH-1:0] r_value;
  logic             r_vv;
  logic             r_ack;
  logic             r_ss;

  logic [1:0]       w_nstate;
  logic [1:0]       w_nsel;
  logic             w_start;
  logic             w_move;
  logic [2:0]       w_pick;
  logic [2:0]       w_low;
  logic [2:0]       w_nxt;
  logic [1:0]       w_cur;
  logic             w_cur_ok;
  logic [WIDTH-1:0] w_src_val;
  logic             w_urg_req;
  logic             w_urg;
  logic             w_done;

  // {found, index} of first valid source circularly after s
  function automatic logic [2:0] f_next(
    input logic [N_SRC-1:0] v,
    input logic [1:0]       s
  );
    logic [2:0] r;
    int k;
    r = '0;
    for (int j = N_SRC; j >= 1; j--) begin
      k = (int'(s) + j) % N_SRC;
      if (v[k]) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  function automatic logic [2:0] f_low(
    input logic [N_SRC-1:0] v
  );
    logic [2:0] r;
    r = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (v[j]) r = {1'b1, 2'(j)};
    end
    return r;
  endfunction

`ifdef ALU_DISP_URGENT_EN
  assign w_urg_req = bus.urgent_req;
`else
  logic w_unused_urg;
  assign w_urg_req    = 1'b0;
  assign w_unused_urg = bus.urgent_req;
`endif

  assign w_urg = w_urg_req && (r_state != ST_URGENT);
  assign w_cur = (r_state == ST_URGENT) ? r_ret : r_sel;
  assign w_low = f_low(bus.src_valid);
  assign w_nxt = f_next(bus.src_valid, w_cur);

  always_comb begin
    w_cur_ok  = 1'b0;
    w_src_val = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (w_cur == 2'(k)) w_cur_ok = bus.src_valid[k];
      if (w_nsel == 2'(k)) w_src_val = bus.src_values[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_move = 1'b0;
    w_pick = w_low;
    unique case (r_state)
      ST_IDLE: w_move = 1'b1;
      ST_SHOW: begin
        w_move = !w_cur_ok || w_done;
        w_pick = w_nxt;
      end
`ifdef ALU_DISP_URGENT_EN
      ST_URGENT: begin
        w_move = w_done;
        if (!r_ret_idle) begin
          w_pick = w_cur_ok ? {1'b1, r_ret} : w_nxt;
        end
      end
`endif
      default: w_move = 1'b1;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_nsel   = r_sel;
    w_start  = 1'b0;
    if (w_urg) begin
      w_nstate = ST_URGENT;
      w_nsel   = (N_SRC < 4) ? SEL_URGENT : r_sel;
      w_start  = 1'b1;
    end else if (w_move) begin
      if (w_pick[2]) begin
        w_nstate = ST_SHOW;
        w_nsel   = w_pick[1:0];
        w_start  = 1'b1;
      end else begin
        w_nstate = ST_IDLE;
      end
    end
  end

  dwell_timer #(.CW(CW)) u_timer (
    .clk        (clk_100MHz),
    .rst        (reset),
    .i_load     (w_start),
    .i_load_val (w_urg ? LD_URG : LD_DWELL),
    .i_en       ((r_state == ST_URGENT) || !bus.hold),
    .o_done     (w_done)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ret      <= '0;
      r_ret_idle <= 1'b0;
      r_value    <= '0;
      r_vv       <= 1'b0;
      r_ack      <= 1'b0;
      r_ss       <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_sel   <= w_nsel;
      r_ss    <= w_start;
      r_ack   <= w_urg;
      r_vv    <= (w_nstate != ST_IDLE);
      if (w_urg) begin
        r_ret      <= r_sel;
        r_ret_idle <= (r_state == ST_IDLE);
        r_value    <= bus.urgent_value;
      end else if (w_nstate == ST_SHOW) begin
        r_value <= w_src_val;
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.value_valid = r_vv;
  assign bus.src_sel     = r_sel;
  assign bus.slot_start  = r_ss;
  assign bus.urgent_ack  = r_ack;

endmodule

// File: doc/alu_display_scheduler.md
# alu_display_scheduler

Time-shares the 6-bit two's-complement display path between several ALU value sources: operand A, operand B and result. Rotates through the valid sources on a fixed dwell period and supports a hold control. Accepts a one-shot urgent value (e.g. overflow report) via request/acknowledge. Sits between the ALU datapath and the 6-bit seven-segment display driver, whose `value` input it feeds.

## Interface
- `N_SRC`, 3: number of time-shared sources (2..4)
- `WIDTH`, 6: source/display value width, two's complement
- `DWELL_CYCLES`, 200_000_000: cycles per source slot (2 s at 100 MHz), ≥2
- `URGENT_CYCLES`, 300_000_000: cycles an urgent value is shown, ≥2
- `clk_100MHz`  in  1  system clock, 100 MHz; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `src_values`  in  N_SRC*WIDTH  packed source values; source i at [i*WIDTH +: WIDTH]
- `src_valid`  in  N_SRC  source i may be displayed
- `hold`  in  1  freeze rotation on current source
- `urgent_req`  in  1  urgent display request, level, held until ack
- `urgent_value`  in  WIDTH  value to show on urgent request
- `urgent_ack`  out  1  one-cycle pulse: urgent request accepted
- `value`  out  WIDTH  value to display driver (registered)
- `value_valid`  out  1  0 = display must blank
- `src_sel`  out  2  index of source shown; 3 during urgent when N_SRC<4, else held
- `slot_start`  out  1  one-cycle pulse on first cycle of every slot (source or urgent)

## Operation
- States: IDLE (no source), SHOW (source `src_sel`), URGENT.
- IDLE: `value_valid`=0. Any `src_valid` bit set → SHOW on lowest valid index, fresh slot.
- SHOW: `value` tracks `src_values[src_sel]` live, one cycle late. Dwell counter loaded with DWELL_CYCLES-1 at slot start. Counter decrements each cycle unless `hold`=1.
- Dwell expiry: advance circularly to next valid index above `src_sel`. If no other source is valid and current is still valid, stay, restart slot, pulse `slot_start`.
- Current source's `src_valid` falls mid-slot: advance next cycle regardless of `hold`. If no source is valid → IDLE.
- Urgent: `urgent_req`=1 in IDLE or SHOW is accepted.
  - `urgent_ack` pulses for one cycle; `urgent_value` is latched.
  - → URGENT for URGENT_CYCLES, `value_valid`=1. `hold` is ignored.
  - On exit, return to the interrupted source if still valid, else the next valid source, else IDLE, with a fresh dwell.
  - `urgent_req` while in URGENT is not acked; it is accepted on the first SHOW/IDLE cycle after exit.
- Simultaneous events: urgent acceptance beats dwell expiry and beats source-drop advance. Source drop beats dwell expiry.
- Arithmetic: counters are unsigned, width `$clog2(max(DWELL_CYCLES,URGENT_CYCLES))`. Values pass through unmodified; no sign handling here.

## Timing
- Reset values: `value`=0, `value_valid`=0, `src_sel`=0, `urgent_ack`=0, `slot_start`=0, state IDLE, counters 0.
- Reset has priority over every event, including mid-URGENT; the latched urgent value is discarded.
- IDLE→SHOW: `slot_start`, `src_sel` and `value` all update in the cycle after `src_valid` is sampled.
- A source slot lasts exactly DWELL_CYCLES cycles with `hold` low, counted from its `slot_start` cycle inclusive. An urgent slot lasts exactly URGENT_CYCLES cycles.
- `urgent_ack` is asserted in the cycle after `urgent_req` is sampled. `slot_start` and the urgent `value` appear in that same cycle.

## Configuration
- `ALU_DISP_URGENT_EN` defined: urgent channel and URGENT state are present.
- Not defined: URGENT state is removed; `urgent_ack` is tied 0; `urgent_req`/`urgent_value` are ignored; all other behaviour is unchanged.

## Structure
- Package `alu_display_pkg`: state encoding (IDLE/SHOW/URGENT), `SEL_URGENT` constant, counter-width helper.
- Sub-module `dwell_timer`: loadable down-counter with enable and one-cycle `done`. Instantiated once and shared by source and urgent slots; the load value is selected by state.

## Test plan
Bench parameters: N_SRC=3, DWELL_CYCLES=4, URGENT_CYCLES=3. Sources A=6'd5, B=6'h3D (-3), R=6'd12.
- All valid after reset → `src_sel` 0,0,0,0,1,1,1,1,2,2,2,2,0. `slot_start` every 4th cycle. `value` 5,…,0x3D,…,12.
- Only `src_valid[1]`=1 → `src_sel` constant 1. `slot_start` every 4 cycles. Clear it → `value_valid`=0 next cycle, state IDLE.
- Source 1 shown, clear `src_valid[1]` at slot cycle 1 → `src_sel`=2 next cycle with `slot_start`, despite `hold`=1.
- `hold`=1 for 10 cycles at slot cycle 2 → no rotation. Release → source changes exactly 2 cycles later.
- `urgent_req` with 6'h20 at slot cycle 2 of source 1 → `urgent_ack` one cycle, `value`=0x20 for 3 cycles, then source 1 with full 4-cycle slot. Urgent coinciding with dwell expiry → urgent wins.
- `reset` during URGENT → all outputs at reset values next cycle. Build without `ALU_DISP_URGENT_EN` → `urgent_ack` never asserted, rotation unaffected.
